// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared 7-segment constants: glyph patterns (active-high {a..g}), bus widths, scan FSM encoding.
// The display encoder uses the same glyph constants.
package seg7_pkg;
    localparam int SEG_W = 7;
    localparam int DIG_N = 4;

    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h7E;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h30;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h33;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h5F;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h70;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h7B;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h1F;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h4E;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h3D;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h47;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD
    } scan_state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] nib;
    } glyph_dec_t;

    // Position of the (single) set bit of a one-hot digit enable.
    function automatic logic [1:0] dig_index(input logic [DIG_N-1:0] d);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < DIG_N; i++)
            if (d[i]) idx = 2'(i);
        return idx;
    endfunction
endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Display pin bundle plus the decoded results seen by a monitor/checker.
interface seven_seg_scan_decoder_if;
    logic [seg7_pkg::SEG_W-1:0] seg;
    logic [seg7_pkg::DIG_N-1:0] dig;
    logic [15:0]                value;
    logic                       frame_valid;
    logic [seg7_pkg::DIG_N-1:0] digit_seen;
    logic                       glyph_err;

    modport master (output seg, dig, input value, frame_valid, digit_seen, glyph_err);
    modport slave  (input seg, dig, output value, frame_valid, digit_seen, glyph_err);
endinterface

// File: rtl/seven_seg_scan_decoder_glyph_decode.sv
// Combinational active-high segment pattern -> {legal, hex nibble}; blank and non-glyphs are illegal.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output glyph_dec_t       dec
);
    always_comb begin
        dec.legal = 1'b1;
        dec.nib   = 4'h0;
        case (pattern)
            GLYPH_0: dec.nib = 4'h0;
            GLYPH_1: dec.nib = 4'h1;
            GLYPH_2: dec.nib = 4'h2;
            GLYPH_3: dec.nib = 4'h3;
            GLYPH_4: dec.nib = 4'h4;
            GLYPH_5: dec.nib = 4'h5;
            GLYPH_6: dec.nib = 4'h6;
            GLYPH_7: dec.nib = 4'h7;
            GLYPH_8: dec.nib = 4'h8;
            GLYPH_9: dec.nib = 4'h9;
            GLYPH_A: dec.nib = 4'hA;
            GLYPH_B: dec.nib = 4'hB;
            GLYPH_C: dec.nib = 4'hC;
            GLYPH_D: dec.nib = 4'hD;
            GLYPH_E: dec.nib = 4'hE;
            GLYPH_F: dec.nib = 4'hF;
            default: dec.legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Receive side of a 4-digit multiplexed 7-segment display: settles each scanned glyph, decodes it,
// and reassembles the 16-bit value once all four digits have been captured.
module seven_seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter int STABLE_CYCLES  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    seven_seg_scan_decoder_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] STAB_THR = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_ONE = CNT_W'(1);

    scan_state_t                state;
    logic [CNT_W-1:0]           stab_cnt;
    logic [SEG_W-1:0]           seg_r, lat_seg;
    logic [DIG_N-1:0]           dig_r, lat_dig;
    logic [DIG_N-1:0][3:0]      shadow, shadow_nx;
    logic [15:0]                value_q;
    logic                       frame_valid_q;
    logic [DIG_N-1:0]           digit_seen_q, seen_nx;
    logic                       glyph_err_q;
    glyph_dec_t                 dec;

    seg7_glyph_decode u_dec (.pattern(lat_seg), .dec(dec));

    // Shadow/seen as they would look after writing the digit being captured; the frame
    // completes on these so the final nibble lands in value in the same cycle.
    always_comb begin
        shadow_nx                     = shadow;
        shadow_nx[dig_index(lat_dig)] = dec.nib;
        seen_nx                       = digit_seen_q | lat_dig;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seg_r         <= '0;
            dig_r         <= '0;
            lat_seg       <= '0;
            lat_dig       <= '0;
            state         <= ST_IDLE;
            stab_cnt      <= '0;
            shadow        <= '0;
            value_q       <= '0;
            frame_valid_q <= 1'b0;
            digit_seen_q  <= '0;
            glyph_err_q   <= 1'b0;
        end else begin
            seg_r         <= SEG_ACTIVE_LOW ? ~bus.seg : bus.seg;
            dig_r         <= DIG_ACTIVE_LOW ? ~bus.dig : bus.dig;
            frame_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if ($onehot(dig_r)) begin
                        state    <= ST_SETTLE;
                        stab_cnt <= STAB_ONE;
                        lat_seg  <= seg_r;
                        lat_dig  <= dig_r;
                    end
                end
                ST_SETTLE: begin
                    if (seg_r == lat_seg && dig_r == lat_dig) begin
                        if (stab_cnt >= STAB_THR) begin
                            stab_cnt <= STAB_MAX;
                            state    <= ST_CAPTURE;
                        end else begin
                            stab_cnt <= stab_cnt + STAB_ONE;
                        end
                    end else if ($onehot(dig_r)) begin
                        stab_cnt <= STAB_ONE;
                        lat_seg  <= seg_r;
                        lat_dig  <= dig_r;
                    end else begin
                        stab_cnt <= '0;
                        state    <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (dec.legal) begin
                        shadow <= shadow_nx;
                        if (&seen_nx) begin
                            value_q       <= shadow_nx;
                            frame_valid_q <= 1'b1;
                            digit_seen_q  <= '0;
                        end else begin
                            digit_seen_q  <= seen_nx;
                        end
                    end else begin
                        glyph_err_q <= 1'b1;
                    end
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Only a change of enable re-arms; segment changes while held are ignored.
                    if (dig_r != lat_dig) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.value       = value_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.digit_seen  = digit_seen_q;
    assign bus.glyph_err   = glyph_err_q;
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: table of full-frame scans plus hand-written corner sequences.
module tb_seven_seg_scan_decoder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fv_cnt = 0;

    seven_seg_scan_decoder_if bus();

    seven_seg_scan_decoder dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    always @(posedge clock) if (bus.frame_valid === 1'b1) fv_cnt++;

    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    typedef struct {
        logic [15:0] digits;
        logic [15:0] exp_value;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_pins(input int k, input logic [6:0] pat);
        logic [3:0] en;
        en = 4'b0001 << k;
        bus.seg = ~pat;
        bus.dig = ~en;
    endtask

    task automatic show(input int k, input logic [3:0] nib, input int cyc);
        set_pins(k, glyph[nib]);
        tick(cyc);
    endtask

    task automatic idle(input int cyc);
        bus.dig = 4'hF;
        bus.seg = 7'h7F;
        tick(cyc);
    endtask

    task automatic scan(input logic [15:0] v);
        for (int k = 0; k < 4; k++) show(k, v[4*k +: 4], 8);
        idle(3);
    endtask

    task automatic do_reset();
        idle(1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        idle(2);
    endtask

    initial begin
        int fv0;
        vecs[0] = '{16'h1234, 16'h1234};
        vecs[1] = '{16'hABCD, 16'hABCD};
        vecs[2] = '{16'h0F0F, 16'h0F0F};
        vecs[3] = '{16'h5678, 16'h5678};
        vecs[4] = '{16'h9E0C, 16'h9E0C};
        vecs[5] = '{16'h6B17, 16'h6B17};

        bus.seg = 7'h7F;
        bus.dig = 4'hF;
        tick(3);
        check("reset_value", bus.value, 16'h0);
        check("reset_fv", bus.frame_valid, 1'b0);
        check("reset_seen", bus.digit_seen, 4'h0);
        check("reset_err", bus.glyph_err, 1'b0);
        reset = 1'b0;
        idle(2);

        // Table-driven full scans, active-low pins, 8 cycles per digit
        foreach (vecs[i]) begin
            fv0 = fv_cnt;
            scan(vecs[i].digits);
            check($sformatf("tbl%0d_frames", i), fv_cnt - fv0, 1);
            check($sformatf("tbl%0d_value", i), bus.value, vecs[i].exp_value);
            check($sformatf("tbl%0d_seen", i), bus.digit_seen, 4'h0);
            check($sformatf("tbl%0d_err", i), bus.glyph_err, 1'b0);
        end

        // One-cycle glitch to 7F on glyph 3 restarts settling
        do_reset();
        set_pins(0, glyph[3]);
        tick(2);
        bus.seg = ~7'h7F;
        tick(1);
        bus.seg = ~glyph[3];
        tick(3);
        check("glitch_not_early", bus.digit_seen, 4'h0);
        tick(2);
        check("glitch_not_at8", bus.digit_seen, 4'h0);
        tick(1);
        check("glitch_captured", bus.digit_seen, 4'h1);
        tick(2);
        fv0 = fv_cnt;
        show(1, 4'h9, 8); show(2, 4'hA, 8); show(3, 4'h7, 8); idle(3);
        check("glitch_frame", fv_cnt - fv0, 1);
        check("glitch_value", bus.value, 16'h7A93);

        // Two enables asserted: no capture, then single enables resume
        idle(3);
        fv0 = fv_cnt;
        show(0, 4'h2, 8);
        check("multi_pre_seen", bus.digit_seen, 4'h1);
        bus.dig = ~4'b0011;
        bus.seg = ~glyph[5];
        tick(20);
        check("multi_seen_hold", bus.digit_seen, 4'h1);
        show(1, 4'h4, 8);
        check("multi_resume", bus.digit_seen, 4'h3);
        show(2, 4'h6, 8); show(3, 4'h8, 8); idle(3);
        check("multi_frame", fv_cnt - fv0, 1);
        check("multi_value", bus.value, 16'h8642);

        // Digit held 100 cycles with a mid-hold segment change: captured once, change ignored
        fv0 = fv_cnt;
        show(0, 4'h5, 50);
        bus.seg = ~7'h00;
        tick(50);
        check("hold_seen", bus.digit_seen, 4'h1);
        check("hold_err", bus.glyph_err, 1'b0);
        idle(3);
        scan(16'hABCD);
        scan(16'hABCD);
        check("hold_frames", fv_cnt - fv0, 2);
        check("hold_value", bus.value, 16'hABCD);

        // Blank glyph on d2: sticky error, no frame until d2 shows a legal glyph
        fv0 = fv_cnt;
        set_pins(2, 7'h00);
        tick(8);
        check("blank_err", bus.glyph_err, 1'b1);
        check("blank_seen", bus.digit_seen, 4'h0);
        show(0, 4'h1, 8); show(1, 4'h2, 8); show(3, 4'h4, 8); idle(3);
        check("blank_seen3", bus.digit_seen, 4'hB);
        check("blank_no_frame", fv_cnt - fv0, 0);
        show(2, 4'h8, 8); idle(3);
        check("blank_frame", fv_cnt - fv0, 1);
        check("blank_value", bus.value, 16'h4821);
        check("blank_err_sticky", bus.glyph_err, 1'b1);

        // Reset after three digits discards everything
        show(0, 4'hF, 8); show(1, 4'h0, 8); show(2, 4'hF, 8);
        check("rst_mid_seen", bus.digit_seen, 4'h7);
        reset = 1'b1;
        tick(1);
        check("rst_value", bus.value, 16'h0);
        check("rst_seen", bus.digit_seen, 4'h0);
        check("rst_err", bus.glyph_err, 1'b0);
        check("rst_fv", bus.frame_valid, 1'b0);
        reset = 1'b0;
        idle(3);
        fv0 = fv_cnt;
        show(3, 4'h0, 8); idle(3);
        check("rst_no_partial", fv_cnt - fv0, 0);
        scan(16'h0F0F);
        check("rst_frame", fv_cnt - fv0, 1);
        check("rst_value2", bus.value, 16'h0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
